// File: rtl/sasc_pkg.sv
// Shared SASC definitions: default data width and a constant-foldable clog2.
package sasc_pkg;

  localparam int SASC_DW = 8;

  // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sasc_fifo_mem.sv
// FIFO storage: 2**AW x DW array, synchronous write, asynchronous read.
// Kept as its own module so it can later be swapped for a RAM macro.
module sasc_fifo_mem
  import sasc_pkg::*;
#(
  parameter int DW = SASC_DW,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  // Write port: store wdata at waddr on an accepted write.
  // NOTE: the array has no reset; clearing it would add a mux per bit and
  // prevent mapping onto a RAM macro. Pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port is combinational so the head entry falls through to dout.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sasc_fifo_gen.sv
// Parametrised first-word-fall-through FIFO with fill level, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sasc_fifo_gen
  import sasc_pkg::*;
#(
  parameter int DW     = SASC_DW,
  parameter int AW     = 2,
  parameter int AF_LVL = 3,
  parameter int AE_LVL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf,
  input  logic          err_clr
);

  // Thresholds sized to the level bus so comparisons stay width-clean.
  localparam logic [AW:0] DEPTH_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF_THR    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_THR    = (AW+1)'(AE_LVL);

  // Pointers carry one wrap bit above the address so full and empty differ.
  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  logic [AW:0] level_w;
  logic        full_w;
  logic        empty_w;
  logic        re_acc;
  logic        we_acc;
  logic        ovf_set;
  logic        udf_set;
  logic        mem_we;

  // Status decode purely from registered pointers.
  always_comb begin
    level_w = wp_q - rp_q;
    full_w  = (level_w == DEPTH_LVL);
    empty_w = (level_w == '0);
  end

  // Next-state for pointers and sticky flags; clr overrides any request.
  // NOTE: every signal gets a default before the branches, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    mem_we  = 1'b0;
    re_acc  = re & ~empty_w;
    we_acc  = we & (~full_w | re_acc);
    ovf_set = we & full_w & ~re_acc;
    udf_set = re & empty_w;
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (we_acc) begin
        wp_d   = wp_q + 1'b1;
        mem_we = rst;
      end
      if (re_acc) begin
        rp_d = rp_q + 1'b1;
      end
      // A new error event in the same cycle as err_clr keeps the flag set.
      ovf_d = ovf_set | (ovf_q & ~err_clr);
      udf_d = udf_set | (udf_q & ~err_clr);
    end
  end

  // State registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  sasc_fifo_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wp_q[AW-1:0]),
    .wdata (din),
    .raddr (rp_q[AW-1:0]),
    .rdata (dout)
  );

  assign level        = level_w;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (level_w >= AF_THR);
  assign almost_empty = (level_w <= AE_THR);
  assign ovf          = ovf_q;
  assign udf          = udf_q;

endmodule

// File: tb/tb_sasc_fifo_gen.sv
// Directed and scoreboard bench for sasc_fifo_gen: a 4x8 instance (A) and a
// 16x16 instance (B) sharing clock and reset.
module tb_sasc_fifo_gen;

  logic clk;
  logic rst;

  // Instance A: DW=8, AW=2, AF=3, AE=1
  logic       a_clr, a_we, a_re, a_err_clr;
  logic [7:0] a_din, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [2:0] a_level;
  logic [8:0] a_stat;

  // Instance B: DW=16, AW=4, AF=14, AE=2
  logic        b_clr, b_we, b_re, b_err_clr;
  logic [15:0] b_din, b_dout;
  logic        b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [4:0]  b_level;
  logic [9:0]  b_stat;

  int checks;
  int failures;

  sasc_fifo_gen #(.DW(8), .AW(2), .AF_LVL(3), .AE_LVL(1)) u_a (
    .clk(clk), .rst(rst), .clr(a_clr), .din(a_din), .we(a_we), .re(a_re),
    .dout(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .level(a_level), .ovf(a_ovf), .udf(a_udf),
    .err_clr(a_err_clr)
  );

  sasc_fifo_gen #(.DW(16), .AW(4), .AF_LVL(14), .AE_LVL(2)) u_b (
    .clk(clk), .rst(rst), .clr(b_clr), .din(b_din), .we(b_we), .re(b_re),
    .dout(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .level(b_level), .ovf(b_ovf), .udf(b_udf),
    .err_clr(b_err_clr)
  );

  assign a_stat = {a_level, a_full, a_empty, a_af, a_ae, a_ovf, a_udf};
  assign b_stat = {b_level, b_full, b_empty, b_af, b_ae, b_ovf, b_udf};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected status word of A for a given fill level and error flags.
  function automatic logic [8:0] a_exp(input int lvl, input bit ovf, input bit udf);
    return {3'(lvl), lvl == 4, lvl == 0, lvl >= 3, lvl <= 1, ovf, udf};
  endfunction

  // Expected status word of B for a given fill level and error flags.
  function automatic logic [9:0] b_exp(input int lvl, input bit ovf, input bit udf);
    return {5'(lvl), lvl == 16, lvl == 0, lvl >= 14, lvl <= 2, ovf, udf};
  endfunction

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [7:0] d);
    a_we = 1'b1; a_din = d; step(); a_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++;
    if (a_stat !== a_exp(0, 0, 0)) begin
      failures++; $display("FAIL reset_a got=%b exp=%b", a_stat, a_exp(0, 0, 0));
    end
    checks++;
    if (b_stat !== b_exp(0, 0, 0)) begin
      failures++; $display("FAIL reset_b got=%b exp=%b", b_stat, b_exp(0, 0, 0));
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      a_we = 1'b1; a_din = vals[i]; step();
      checks++;
      if (a_stat !== a_exp(i + 1, 0, 0) || a_dout !== 8'h11) begin
        failures++;
        $display("FAIL fill_%0d got=%b/%h exp=%b/11", i, a_stat, a_dout, a_exp(i + 1, 0, 0));
      end
    end
    a_we = 1'b0;
    a_re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_dout !== vals[i]) begin
        failures++; $display("FAIL drain_dout_%0d got=%h exp=%h", i, a_dout, vals[i]);
      end
      step();
      checks++;
      if (a_stat !== a_exp(3 - i, 0, 0)) begin
        failures++; $display("FAIL drain_stat_%0d got=%b exp=%b", i, a_stat, a_exp(3 - i, 0, 0));
      end
    end
    a_re = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) a_push(8'hA0 + 8'(i));
    a_we = 1'b1; a_din = 8'h55; step(); a_we = 1'b0;
    checks++;
    if (a_stat !== a_exp(4, 1, 0)) begin
      failures++; $display("FAIL ovf_set got=%b exp=%b", a_stat, a_exp(4, 1, 0));
    end
    a_err_clr = 1'b1; step(); a_err_clr = 1'b0;
    checks++;
    if (a_stat !== a_exp(4, 0, 0)) begin
      failures++; $display("FAIL ovf_clr got=%b exp=%b", a_stat, a_exp(4, 0, 0));
    end
    // err_clr together with a fresh overflow: flag must remain set.
    a_we = 1'b1; a_err_clr = 1'b1; a_din = 8'h56; step(); a_we = 1'b0;
    checks++;
    if (a_stat !== a_exp(4, 1, 0)) begin
      failures++; $display("FAIL ovf_set_wins got=%b exp=%b", a_stat, a_exp(4, 1, 0));
    end
    step(); a_err_clr = 1'b0;
    a_re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_dout !== 8'hA0 + 8'(i)) begin
        failures++; $display("FAIL ovf_contents_%0d got=%h exp=%h", i, a_dout, 8'hA0 + 8'(i));
      end
      step();
    end
    a_re = 1'b0;
    checks++;
    if (a_stat !== a_exp(0, 0, 0)) begin
      failures++; $display("FAIL ovf_drained got=%b exp=%b", a_stat, a_exp(0, 0, 0));
    end
  endtask

  task automatic test_underflow();
    a_we = 1'b1; a_re = 1'b1; a_din = 8'h66; step(); a_we = 1'b0; a_re = 1'b0;
    checks++;
    if (a_stat !== a_exp(1, 0, 1) || a_dout !== 8'h66) begin
      failures++; $display("FAIL udf_wr got=%b/%h exp=%b/66", a_stat, a_dout, a_exp(1, 0, 1));
    end
    a_err_clr = 1'b1; a_re = 1'b1; step(); a_err_clr = 1'b0;
    checks++;
    if (a_stat !== a_exp(0, 0, 0)) begin
      failures++; $display("FAIL udf_clr got=%b exp=%b", a_stat, a_exp(0, 0, 0));
    end
    step(); a_re = 1'b0;
    checks++;
    if (a_stat !== a_exp(0, 0, 1)) begin
      failures++; $display("FAIL udf_plain got=%b exp=%b", a_stat, a_exp(0, 0, 1));
    end
    a_err_clr = 1'b1; step(); a_err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [$];
    for (int i = 0; i < 4; i++) begin
      a_push(8'h70 + 8'(i));
      q.push_back(8'h70 + 8'(i));
    end
    a_we = 1'b1; a_re = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_din = 8'h77 + 8'(i);
      checks++;
      if (a_dout !== q[0]) begin
        failures++; $display("FAIL b2b_dout_%0d got=%h exp=%h", i, a_dout, q[0]);
      end
      step();
      void'(q.pop_front());
      q.push_back(8'h77 + 8'(i));
      checks++;
      if (a_stat !== a_exp(4, 0, 0)) begin
        failures++; $display("FAIL b2b_stat_%0d got=%b exp=%b", i, a_stat, a_exp(4, 0, 0));
      end
    end
    a_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_dout !== q[i]) begin
        failures++; $display("FAIL b2b_order_%0d got=%h exp=%h", i, a_dout, q[i]);
      end
      step();
    end
    a_re = 1'b0;
  endtask

  task automatic test_clr_reset();
    a_re = 1'b1; step(); a_re = 1'b0;
    a_push(8'h01); a_push(8'h02);
    checks++;
    if (a_stat !== a_exp(2, 0, 1)) begin
      failures++; $display("FAIL clr_pre got=%b exp=%b", a_stat, a_exp(2, 0, 1));
    end
    a_clr = 1'b1; a_we = 1'b1; a_din = 8'h99; step(); a_clr = 1'b0; a_we = 1'b0;
    checks++;
    if (a_stat !== a_exp(0, 0, 0)) begin
      failures++; $display("FAIL clr got=%b exp=%b", a_stat, a_exp(0, 0, 0));
    end
    a_push(8'h05);
    checks++;
    if (a_stat !== a_exp(1, 0, 0) || a_dout !== 8'h05) begin
      failures++; $display("FAIL clr_after got=%b/%h exp=%b/05", a_stat, a_dout, a_exp(1, 0, 0));
    end
    a_we = 1'b1; a_din = 8'hCC; step(); a_din = 8'hDD; step();
    rst = 1'b0; a_din = 8'hEE; step(); rst = 1'b1; a_we = 1'b0;
    checks++;
    if (a_stat !== a_exp(0, 0, 0)) begin
      failures++; $display("FAIL rst_mid got=%b exp=%b", a_stat, a_exp(0, 0, 0));
    end
  endtask

  task automatic test_wide();
    logic [15:0] q [$];
    for (int i = 0; i < 16; i++) begin
      b_we = 1'b1; b_din = 16'h1000 + 16'(i); step();
      q.push_back(16'h1000 + 16'(i));
      checks++;
      if (b_stat !== b_exp(i + 1, 0, 0)) begin
        failures++; $display("FAIL wide_fill_%0d got=%b exp=%b", i, b_stat, b_exp(i + 1, 0, 0));
      end
    end
    b_din = 16'hBEEF; step(); b_we = 1'b0;
    checks++;
    if (b_stat !== b_exp(16, 1, 0)) begin
      failures++; $display("FAIL wide_ovf got=%b exp=%b", b_stat, b_exp(16, 1, 0));
    end
    b_err_clr = 1'b1; step(); b_err_clr = 1'b0;
    b_we = 1'b1; b_re = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_din = 16'h7700 + 16'(i); step();
      void'(q.pop_front());
      q.push_back(16'h7700 + 16'(i));
    end
    b_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (b_dout !== q[i]) begin
        failures++; $display("FAIL wide_order_%0d got=%h exp=%h", i, b_dout, q[i]);
      end
      step();
      checks++;
      if (b_stat !== b_exp(15 - i, 0, 0)) begin
        failures++; $display("FAIL wide_drain_%0d got=%b exp=%b", i, b_stat, b_exp(15 - i, 0, 0));
      end
    end
    b_we = 1'b1; b_din = 16'h6666; step(); b_we = 1'b0; b_re = 1'b0;
    checks++;
    if (b_stat !== b_exp(1, 0, 1) || b_dout !== 16'h6666) begin
      failures++; $display("FAIL wide_udf got=%b/%h exp=%b/6666", b_stat, b_dout, b_exp(1, 0, 1));
    end
  endtask

  task automatic test_random();
    logic [15:0] q [$];
    bit          we_r, re_r, ec_r, re_ok, we_ok, m_ovf, m_udf;
    logic [15:0] d_r;
    int          n;
    b_clr = 1'b1; step(); b_clr = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      // Alternate fill-biased and drain-biased phases to reach both ends.
      we_r = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      re_r = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ec_r = ($urandom_range(0, 15) == 0);
      d_r  = 16'($urandom);
      b_we = we_r; b_re = re_r; b_err_clr = ec_r; b_din = d_r;
      n     = q.size();
      re_ok = re_r && n > 0;
      we_ok = we_r && (n < 16 || re_ok);
      m_ovf = (we_r && n == 16 && !re_ok) || (m_ovf && !ec_r);
      m_udf = (re_r && n == 0) || (m_udf && !ec_r);
      if (re_ok) void'(q.pop_front());
      if (we_ok) q.push_back(d_r);
      step();
      checks++;
      if (b_stat !== b_exp(q.size(), m_ovf, m_udf) || (q.size() > 0 && b_dout !== q[0])) begin
        failures++;
        $display("FAIL rand_%0d got=%b/%h exp=%b/%h", i, b_stat, b_dout,
                 b_exp(q.size(), m_ovf, m_udf), (q.size() > 0) ? q[0] : 16'h0);
      end
    end
    b_we = 1'b0; b_re = 1'b0; b_err_clr = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    a_clr = 1'b0; a_we = 1'b0; a_re = 1'b0; a_err_clr = 1'b0; a_din = '0;
    b_clr = 1'b0; b_we = 1'b0; b_re = 1'b0; b_err_clr = 1'b0; b_din = '0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_clr_reset();
    test_wide();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
